spi_omega_rx: RTL and testbench
===============================

// Module: spi_omega_rx
// PURPOSE
//  SPI slave front end. Receives one 40-bit omega tuning word per frame from the host MCU.
//  Synchronises sckPort/mosiPort/sselPort into the CLK67MHZ domain and shifts data in MSB first.
//  Commits the word on frame end. omegaOut feeds the bit shifter / divider stage directly.
//  Any omegaOut change is a new word, so the output only changes on a valid, complete frame.
// PARAMETERS
//  WORD_W       40  bits per frame and omegaOut width
//  SYNC_STAGES  2   flip-flops per input synchroniser (>=2)
// PORTS
//  CLK67MHZ    in   1       system clock; the only clock
//  resetPort   in   1       reset, asynchronous, active-low
//  sckPort     in   1       SPI clock, mode 0 (CPOL=0, CPHA=0), max CLK67MHZ/4
//  mosiPort    in   1       SPI data in
//  sselPort    in   1       SPI select, active-low
//  misoPort    out  1       SPI data out (exists only with SPI_OMEGA_MISO_EN)
//  omegaOut    out  WORD_W  last committed omega word
//  omegaValid  out  1       1-cycle pulse on commit
//  frameErr    out  1       1-cycle pulse when a frame ends with bit count != WORD_W
// BEHAVIOUR
//  Reset (resetPort=0, async): all registers clear.
//   - Outputs: omegaOut=0, omegaValid=0, frameErr=0, misoPort=0.
//   - State goes to IDLE and the synchronisers clear to ssel=1, sck=0.
//  Edge detection uses synchronised signals only: sck_rise, sck_fall, ssel_fall, ssel_rise.
//  States:
//   - IDLE: on ssel_fall -> SHIFT. shift_reg=0, bitcnt=0.
//   - SHIFT, on sck_rise: shift_reg <= {shift_reg[WORD_W-2:0], mosi_s}.
//     bitcnt increments and saturates at WORD_W+1.
//   - SHIFT, on ssel_rise -> IDLE:
//     * bitcnt==WORD_W: omegaOut<=shift_reg and omegaValid=1 for the next cycle.
//     * otherwise: frameErr=1 for the next cycle and omegaOut holds.
//  Latency: sselPort rising at the pin -> omegaOut/omegaValid update in SYNC_STAGES+2 cycles (4 by default).
//  Boundary conditions:
//   - sck_rise and ssel_rise in the same cycle: ssel_rise wins. The bit is dropped and the count is checked as-is.
//   - sck edges while ssel is high: ignored.
//   - ssel_fall while in SHIFT (glitch): impossible without an intervening rise; no special handling.
//   - More than WORD_W bits (overrun): frameErr, no commit.
//   - Zero-bit frame (ssel low then high): frameErr.
//   - Reset mid-frame: frame discarded. If sselPort is already low at reset release, no frame starts until a fresh ssel_fall.
//   - Back-to-back frames: ssel_rise followed by ssel_fall one sync delay later is accepted.
//   - Committing the same value twice: omegaValid pulses, omegaOut value unchanged.
// CONFIGURATION
//  SPI_OMEGA_MISO_EN defined: misoPort exists and echoes the previously committed omegaOut, MSB first.
//   - tx_reg loads omegaOut on ssel_fall and misoPort drives tx_reg[WORD_W-1] immediately.
//   - tx_reg shifts left on each sck_fall in SHIFT.
//   - misoPort=0 in IDLE.
//   - The host reads back word N-1 while writing word N.
//  SPI_OMEGA_MISO_EN undefined: no misoPort and no tx_reg logic; receive behaviour is identical.
// STRUCTURE
//  spi_omega_pkg:
//   - localparams WORD_W_DEF=40, SYNC_STAGES_DEF=2.
//   - State encoding ST_IDLE=1'b0, ST_SHIFT=1'b1.
//   - Bit-count width function clog2(WORD_W+2).
//  Sub-module sync_edge_det (SYNC_STAGES param; outputs level, rise, fall):
//   - Instantiated for sck and ssel.
//   - mosi uses a plain SYNC_STAGES synchroniser aligned to the sck path.
//  Top holds the FSM, shift_reg, bitcnt, commit register and the optional tx_reg.
// TESTING
//  1. Frame of 40 bits 0x12_3456_789A at sck=CLK/8 -> omegaOut=0x123456789A, one omegaValid pulse, frameErr=0.
//  2. Frame of 39 bits after test 1 -> frameErr pulse, omegaOut stays 0x123456789A, no omegaValid.
//  3. Frame of 41 bits (0xFF..FF plus 1) -> frameErr pulse, omegaOut unchanged.
//  4. Assert resetPort=0 after bit 20 of a frame, release with ssel still low, then finish clocking -> omegaOut=0, no pulses.
//     Next full frame 0x0000000001 -> commits.
//  5. Two back-to-back frames 0xAAAAAAAAAA then 0x5555555555 with minimum ssel-high gap -> two omegaValid pulses.
//     Final omegaOut=0x5555555555.
//  6. (SPI_OMEGA_MISO_EN) After test 5, send frame 0x0 -> misoPort bits read MSB first = 0x5555555555.

Source files
------------

// File: rtl/spi_omega_pkg.sv
// Shared types and constants for the SPI omega-word receiver.
package spi_omega_pkg;
    localparam int WORD_W_DEF      = 40;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/spi_omega_rx_sync_edge_det.sv
// Multi-flop synchroniser with registered level and edge pulses.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;

    // level is the delayed copy so rise/fall line up with it in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= {SYNC_STAGES{RST_VAL}};
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], din};
            level <= sync[SYNC_STAGES-1];
            rise  <= sync[SYNC_STAGES-1] & ~level;
            fall  <= ~sync[SYNC_STAGES-1] & level;
        end
    end
endmodule

// File: rtl/spi_omega_rx.sv
// SPI mode-0 slave receiving one omega word per frame; commits only on complete frames.
// Optional MISO echo of the previously committed word: SPI_OMEGA_MISO_EN.
module spi_omega_rx
    import spi_omega_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              CLK67MHZ,
    input  logic              resetPort,
    input  logic              sckPort,
    input  logic              mosiPort,
    input  logic              sselPort,
`ifdef SPI_OMEGA_MISO_EN
    output logic              misoPort,
`endif
    output logic [WORD_W-1:0] omegaOut,
    output logic              omegaValid,
    output logic              frameErr
);
    localparam int CW = clog2(WORD_W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WORD_W + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic ssel_lvl, ssel_rise, ssel_fall;
    logic [SYNC_STAGES:0] mosi_pipe;
    logic [SYNC_STAGES:0] settle;
    logic                 armed;
    logic                 mosi_s, start;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   shift_reg, shift_nxt, omega_nxt;
    logic [CW-1:0]       bitcnt, cnt_nxt;
    logic                valid_nxt, err_nxt;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(CLK67MHZ), .rst_n(resetPort), .din(sckPort),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel (
        .clk(CLK67MHZ), .rst_n(resetPort), .din(sselPort),
        .level(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall)
    );

    assign mosi_s = mosi_pipe[SYNC_STAGES];
    // A low ssel seen while the synchroniser flushes after reset is not a frame start
    assign start  = (state == ST_IDLE) && ssel_fall && armed;

    always_ff @(posedge CLK67MHZ or negedge resetPort) begin
        if (!resetPort) begin
            mosi_pipe  <= '0;
            settle     <= '0;
            armed      <= 1'b0;
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bitcnt     <= '0;
            omegaOut   <= '0;
            omegaValid <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            mosi_pipe  <= {mosi_pipe[SYNC_STAGES-1:0], mosiPort};
            settle     <= {settle[SYNC_STAGES-1:0], 1'b1};
            armed      <= armed | (settle[SYNC_STAGES] & ssel_lvl);
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bitcnt     <= cnt_nxt;
            omegaOut   <= omega_nxt;
            omegaValid <= valid_nxt;
            frameErr   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bitcnt;
        omega_nxt = omegaOut;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                // frame end takes priority; a coincident sck edge is dropped
                if (ssel_rise) begin
                    state_nxt = ST_IDLE;
                    if (bitcnt == CNT_FULL) begin
                        omega_nxt = shift_reg;
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (sck_rise) begin
                    shift_nxt = {shift_reg[WORD_W-2:0], mosi_s};
                    if (bitcnt != CNT_SAT) cnt_nxt = bitcnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef SPI_OMEGA_MISO_EN
    logic [WORD_W-1:0] tx_reg;
    logic              unused_sck;

    assign unused_sck = sck_lvl;

    always_ff @(posedge CLK67MHZ or negedge resetPort) begin
        if (!resetPort)
            tx_reg <= '0;
        else if (start)
            tx_reg <= omegaOut;
        else if (state == ST_SHIFT && sck_fall && !ssel_rise)
            tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
    end

    assign misoPort = (state == ST_SHIFT) ? tx_reg[WORD_W-1] : 1'b0;
`else
    logic unused_sck;
    assign unused_sck = sck_lvl ^ sck_fall;
`endif
endmodule

// File: tb/tb_spi_omega_rx.sv
// Randomised self-checking bench for spi_omega_rx against a frame-level model.
module tb_spi_omega_rx;
    localparam int W = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sck = 1'b0, mosi = 1'b0, ssel = 1'b1;
    logic [W-1:0] omega;
    logic         valid, err;
`ifdef SPI_OMEGA_MISO_EN
    logic         miso;
`endif

    int total = 0, bad = 0;
    int valid_cnt = 0, err_cnt = 0;
    int exp_valid = 0, exp_err = 0;
    logic [W-1:0] exp_omega = '0;

    spi_omega_rx dut (
        .CLK67MHZ(clk), .resetPort(rst_n), .sckPort(sck), .mosiPort(mosi), .sselPort(ssel),
`ifdef SPI_OMEGA_MISO_EN
        .misoPort(miso),
`endif
        .omegaOut(omega), .omegaValid(valid), .frameErr(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) valid_cnt++;
        if (err) err_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clock n bits MSB first; host samples miso just before each rising sck
    task automatic spi_bits(input logic [63:0] data, input int n, input int half,
                            inout logic [63:0] rd);
        for (int i = 0; i < n; i++) begin
            mosi = data[n-1-i];
            cycles(half);
`ifdef SPI_OMEGA_MISO_EN
            rd = {rd[62:0], miso};
`endif
            sck = 1'b1;
            cycles(half);
            sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [63:0] data, input int nbits, input int half,
                             input int gap, output logic [63:0] rd);
        rd = '0;
        ssel = 1'b0;
        cycles(8);
        spi_bits(data, nbits, half, rd);
        cycles(half);
        ssel = 1'b1;
        cycles(gap);
        if (nbits == W) begin
            exp_omega = data[W-1:0];
            exp_valid++;
        end else begin
            exp_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        total++; if (omega !== '0) begin $display("FAIL reset_omega got=%h want=0", omega); bad++; end
        total++; if (valid !== 1'b0) begin $display("FAIL reset_valid got=%b want=0", valid); bad++; end
        total++; if (err !== 1'b0) begin $display("FAIL reset_err got=%b want=0", err); bad++; end
`ifdef SPI_OMEGA_MISO_EN
        total++; if (miso !== 1'b0) begin $display("FAIL reset_miso got=%b want=0", miso); bad++; end
`endif
        rst_n = 1'b1;
        cycles(6);
        total++; if (omega !== '0) begin $display("FAIL post_reset_omega got=%h want=0", omega); bad++; end
    endtask

    task automatic test_basic();
        logic [63:0] rd;
        spi_frame(64'h12_3456_789A, 40, 4, 8, rd);
        total++; if (omega !== 40'h12_3456_789A) begin $display("FAIL basic_omega got=%h want=123456789a", omega); bad++; end
        total++; if (valid_cnt !== exp_valid) begin $display("FAIL basic_valid got=%0d want=%0d", valid_cnt, exp_valid); bad++; end
        total++; if (err_cnt !== exp_err) begin $display("FAIL basic_err got=%0d want=%0d", err_cnt, exp_err); bad++; end
    endtask

    task automatic test_bad_len(input int nbits, input logic [63:0] data);
        logic [63:0] rd;
        spi_frame(data, nbits, 4, 8, rd);
        total++; if (omega !== exp_omega) begin $display("FAIL len%0d_omega got=%h want=%h", nbits, omega, exp_omega); bad++; end
        total++; if (valid_cnt !== exp_valid) begin $display("FAIL len%0d_valid got=%0d want=%0d", nbits, valid_cnt, exp_valid); bad++; end
        total++; if (err_cnt !== exp_err) begin $display("FAIL len%0d_err got=%0d want=%0d", nbits, err_cnt, exp_err); bad++; end
    endtask

    task automatic test_mid_reset();
        logic [63:0] d, rd;
        d = {$urandom, $urandom};
        rd = '0;
        ssel = 1'b0;
        cycles(8);
        spi_bits(d, 20, 4, rd);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        spi_bits(d, 20, 4, rd);
        cycles(4);
        ssel = 1'b1;
        cycles(8);
        exp_omega = '0;
        total++; if (omega !== '0) begin $display("FAIL midrst_omega got=%h want=0", omega); bad++; end
        total++; if (valid_cnt !== exp_valid) begin $display("FAIL midrst_valid got=%0d want=%0d", valid_cnt, exp_valid); bad++; end
        total++; if (err_cnt !== exp_err) begin $display("FAIL midrst_err got=%0d want=%0d", err_cnt, exp_err); bad++; end
        spi_frame(64'h1, 40, 4, 8, rd);
        total++; if (omega !== 40'h1) begin $display("FAIL midrst_next_omega got=%h want=1", omega); bad++; end
        total++; if (valid_cnt !== exp_valid) begin $display("FAIL midrst_next_valid got=%0d want=%0d", valid_cnt, exp_valid); bad++; end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd;
        spi_frame(64'hAA_AAAA_AAAA, 40, 3, 3, rd);
        spi_frame(64'h55_5555_5555, 40, 3, 10, rd);
        total++; if (omega !== 40'h55_5555_5555) begin $display("FAIL b2b_omega got=%h want=5555555555", omega); bad++; end
        total++; if (valid_cnt !== exp_valid) begin $display("FAIL b2b_valid got=%0d want=%0d", valid_cnt, exp_valid); bad++; end
        total++; if (err_cnt !== exp_err) begin $display("FAIL b2b_err got=%0d want=%0d", err_cnt, exp_err); bad++; end
    endtask

`ifdef SPI_OMEGA_MISO_EN
    task automatic test_miso();
        logic [63:0] rd;
        logic [W-1:0] prev;
        prev = exp_omega;
        spi_frame(64'h0, 40, 8, 10, rd);
        total++; if (rd[W-1:0] !== prev) begin $display("FAIL miso_readback got=%h want=%h", rd[W-1:0], prev); bad++; end
        total++; if (omega !== '0) begin $display("FAIL miso_omega got=%h want=0", omega); bad++; end
    endtask
`endif

    task automatic test_same_value();
        logic [63:0] rd;
        logic [W-1:0] v;
        v = exp_omega;
        spi_frame({24'h0, v}, 40, 4, 8, rd);
        total++; if (omega !== v) begin $display("FAIL same_omega got=%h want=%h", omega, v); bad++; end
        total++; if (valid_cnt !== exp_valid) begin $display("FAIL same_valid got=%0d want=%0d", valid_cnt, exp_valid); bad++; end
    endtask

    task automatic test_random();
        logic [63:0] d, rd;
        logic [W-1:0] prev;
        int n, half;
        for (int k = 0; k < 14; k++) begin
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(38, 42)) : W;
            d = {$urandom, $urandom};
            half = $urandom_range(2, 6);
            prev = exp_omega;
            spi_frame(d, n, half, $urandom_range(7, 12), rd);
            total++; if (omega !== exp_omega) begin $display("FAIL rnd%0d_omega n=%0d got=%h want=%h", k, n, omega, exp_omega); bad++; end
            total++; if (valid_cnt !== exp_valid || err_cnt !== exp_err) begin
                $display("FAIL rnd%0d_pulses got=%0d/%0d want=%0d/%0d", k, valid_cnt, err_cnt, exp_valid, exp_err); bad++; end
`ifdef SPI_OMEGA_MISO_EN
            if (n == W && half >= 6) begin
                total++; if (rd[W-1:0] !== prev) begin $display("FAIL rnd%0d_miso got=%h want=%h", k, rd[W-1:0], prev); bad++; end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_len(39, 64'h12_3456_789A);
        test_bad_len(41, 64'h1FF_FFFF_FFFF);
        test_bad_len(0, 64'h0);
        test_mid_reset();
        test_back_to_back();
`ifdef SPI_OMEGA_MISO_EN
        test_miso();
`endif
        test_same_value();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
